uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised oversampling UART receiver with a receive FIFO, replacing the fixed 16x, 8-bit, no-parity receive path used by the core's UART peripheral and bench monitors.
- Samples `rx` on a single-cycle baud-tick enable at OVERSAMPLE × baud. Samples at mid-bit rather than at end-of-bit.
- Validates the start bit, and optionally checks parity.
- Queues good frames for the MMIO read side.
- Flags framing, parity and overrun errors.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, b_tick pulses per bit period (even, ≥4)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
DEPTH, 4, FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  system clock
Rst  in  1  synchronous active-high reset
b_tick  in  1  oversample enable, one-cycle pulse at OVERSAMPLE × baud
rx  in  1  serial input, idle high, asynchronous to clk
rd_en  in  1  pop head entry
rd_data  out  DATA_BITS  head entry (first-word fall-through)
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  $clog2(DEPTH+1)  entries held
busy  out  1  receiver not in IDLE
frame_err  out  1  one-cycle pulse: stop bit sampled 0
parity_err  out  1  one-cycle pulse: parity mismatch
overrun_err  out  1  one-cycle pulse: good frame dropped, FIFO full

Behaviour:
Reset and clocking
- Single clock domain. Reset is synchronous and active-high: `Rst` is sampled on the rising edge of `clk`.
- Reset values: rd_data = 0, empty = 1, full = 0, count = 0, busy = 0, all error pulses 0, state = IDLE, rx synchroniser = 1.
- Reset asserted mid-frame aborts the frame. Nothing is pushed and no error pulses.

Input synchroniser
- `rx` passes through a 2-FF synchroniser to give rx_s, adding 2 clk of latency.
- The FSM only advances on cycles where b_tick = 1. All counters hold otherwise.

Receive FSM (tick counter cnt, bit index idx)
- IDLE: if rx_s == 0 → START, cnt = 0.
- START: cnt increments. At cnt == OVERSAMPLE/2−1 (mid start bit):
  - rx_s == 0 → DATA, cnt = 0, idx = 0.
  - rx_s == 1 → IDLE (glitch rejected, no error).
- DATA: at cnt == OVERSAMPLE−1, shift[idx] = rx_s and cnt = 0. After idx == DATA_BITS−1 → PARITY if PARITY_MODE ≠ 0, else STOP.
- PARITY: at cnt == OVERSAMPLE−1, capture the parity bit.
  - Even: XOR(data, parity bit) must be 0.
  - Odd: XOR(data, parity bit) must be 1.
  - Go to STOP.
- STOP: at cnt == OVERSAMPLE−1, sample rx_s, then resolve the frame in this priority order:
  - rx_s == 0 → frame_err pulse, frame dropped.
  - else parity bad → parity_err pulse, frame dropped.
  - else FIFO full and no rd_en → overrun_err pulse, frame dropped.
  - else push.
  - In every case → IDLE in the same cycle, so the next start bit is detected from the following tick onward.
- busy = (state ≠ IDLE).

FIFO
- Circular buffer with wrapping read and write pointers.
- rd_data always shows the head entry. It is 0 when the FIFO is empty.
- Push is visible on the next clk edge: empty deasserts and count increments.
- rd_en while empty is ignored.
- Simultaneous push and pop:
  - count is unchanged.
  - When full, the push is accepted because the pop frees a slot in the same cycle, so there is no overrun.
- full = (count == DEPTH). empty = (count == 0).
- Error pulses are high for exactly one clk, registered on the resolving cycle.

Test Plan:
1. Defaults, b_tick tied high (bit = 16 clk). Send 0x61, 0x62, 0x63, 0x64 with 1 idle bit between, no reads → count = 4, full = 1. Four pops return 0x61, 0x62, 0x63, 0x64, then empty = 1.
2. rx low for 4 ticks then high → START returns to IDLE, busy deasserts, count = 0, no error pulses.
3. PARITY_MODE = 1. Send 0x07 with parity 1 → pushed. Send 0x07 with parity 0 → parity_err pulse, count unchanged. Repeat with PARITY_MODE = 2 and the opposite parity values.
4. Send 0x55 with stop bit 0 → frame_err pulse, nothing pushed. Next correct frame 0xAA → pushed.
5. DEPTH = 4. Send 5 bytes 0x01..0x05 with no reads → overrun_err on the 5th, FIFO holds 0x01..0x04. Repeat, asserting rd_en in the 5th frame's resolving cycle → no overrun, FIFO holds 0x02..0x05.
6. Assert Rst for 1 cycle during DATA bit 3 of 0x3C → all outputs at reset values. Next complete frame 0x3C is received correctly. Also check DATA_BITS = 7, OVERSAMPLE = 8 with 0x5A → rd_data = 0x5A.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver: 2-FF rx synchroniser, mid-bit sampling FSM with optional
// parity, and a first-word fall-through receive FIFO with framing/parity/overrun pulses.
//
// state    | meaning
// S_IDLE   | line idle, waiting for rx_s low
// S_START  | timing to mid start bit, rejects glitches
// S_DATA   | sampling data bits LSB first at mid-bit
// S_PARITY | sampling the parity bit
// S_STOP   | sampling the stop bit, then resolving push/error
module uart_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         Rst,
    input  logic                         b_tick,
    input  logic                         rx,
    input  logic                         rd_en,
    output logic [DATA_BITS-1:0]         rd_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic                         overrun_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   rx_meta_q, rx_s_q;
    logic [DATA_BITS-1:0]   mem_q [DEPTH];
    logic [DATA_BITS-1:0]   mem_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]          count_q, count_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_err_q, overrun_err_d;
    logic                   push, pop, par_xor, par_bad;

    assign empty       = (count_q == '0);
    assign full        = (count_q == NW'(DEPTH));
    assign count       = count_q;
    assign busy        = (state_q != S_IDLE);
    assign rd_data     = empty ? '0 : mem_q[rd_ptr_q];
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;

    // Timers count down from the interval length and act on reaching zero.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        par_d         = par_q;
        push          = 1'b0;
        frame_err_d   = 1'b0;
        parity_err_d  = 1'b0;
        overrun_err_d = 1'b0;
        par_xor       = (^shift_q) ^ par_q;
        if (PARITY_MODE == 1)      par_bad = par_xor;
        else if (PARITY_MODE == 2) par_bad = ~par_xor;
        else                       par_bad = 1'b0;

        if (b_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = HALF_M1;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            cnt_d   = FULL_M1;
                            idx_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_d[idx_q] = rx_s_q;
                        cnt_d          = FULL_M1;
                        if (idx_q == LAST_IDX) state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        else                   idx_d   = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == '0) begin
                        par_d   = rx_s_q;
                        cnt_d   = FULL_M1;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        if (!rx_s_q)              frame_err_d   = 1'b1;
                        else if (par_bad)         parity_err_d  = 1'b1;
                        else if (full && !rd_en)  overrun_err_d = 1'b1;
                        else                      push          = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A pop while full frees the slot the simultaneous push lands in.
    always_comb begin
        pop      = rd_en && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            rx_meta_q     <= rx;
            rx_s_q        <= rx_meta_q;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: four configurations driven with serial frames, checked against a
// queue-based model of the frame resolution rules and the receive FIFO.
module tb_uart_rx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       b_tick;
    logic       rx [4];
    logic       rd_en [4];
    logic       rst [4];
    logic [7:0] rdd0, rdd1, rdd2;
    logic [6:0] rdd3;
    logic       empty_w [4];
    logic       full_w [4];
    logic       busy_w [4];
    logic       fe_w [4];
    logic       pe_w [4];
    logic       oe_w [4];
    logic [2:0] cnt_w [4];
    logic [8:0] rdv [4];

    int total = 0;
    int bad   = 0;
    int fe_c [4];
    int pe_c [4];
    int oe_c [4];
    int exp_fe [4];
    int exp_pe [4];
    int exp_oe [4];
    logic [8:0] mq [4][$];

    uart_rx_fifo #(.PARITY_MODE(0)) u0 (.clk(clk), .Rst(rst[0]), .b_tick(b_tick), .rx(rx[0]),
        .rd_en(rd_en[0]), .rd_data(rdd0), .empty(empty_w[0]), .full(full_w[0]), .count(cnt_w[0]),
        .busy(busy_w[0]), .frame_err(fe_w[0]), .parity_err(pe_w[0]), .overrun_err(oe_w[0]));
    uart_rx_fifo #(.PARITY_MODE(1)) u1 (.clk(clk), .Rst(rst[1]), .b_tick(b_tick), .rx(rx[1]),
        .rd_en(rd_en[1]), .rd_data(rdd1), .empty(empty_w[1]), .full(full_w[1]), .count(cnt_w[1]),
        .busy(busy_w[1]), .frame_err(fe_w[1]), .parity_err(pe_w[1]), .overrun_err(oe_w[1]));
    uart_rx_fifo #(.PARITY_MODE(2)) u2 (.clk(clk), .Rst(rst[2]), .b_tick(b_tick), .rx(rx[2]),
        .rd_en(rd_en[2]), .rd_data(rdd2), .empty(empty_w[2]), .full(full_w[2]), .count(cnt_w[2]),
        .busy(busy_w[2]), .frame_err(fe_w[2]), .parity_err(pe_w[2]), .overrun_err(oe_w[2]));
    uart_rx_fifo #(.DATA_BITS(7), .OVERSAMPLE(8)) u3 (.clk(clk), .Rst(rst[3]), .b_tick(b_tick),
        .rx(rx[3]), .rd_en(rd_en[3]), .rd_data(rdd3), .empty(empty_w[3]), .full(full_w[3]),
        .count(cnt_w[3]), .busy(busy_w[3]), .frame_err(fe_w[3]), .parity_err(pe_w[3]),
        .overrun_err(oe_w[3]));

    always_comb begin
        rdv[0] = {1'b0, rdd0};
        rdv[1] = {1'b0, rdd1};
        rdv[2] = {1'b0, rdd2};
        rdv[3] = {2'b0, rdd3};
    end

    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (fe_w[u] === 1'b1) fe_c[u]++;
            if (pe_w[u] === 1'b1) pe_c[u]++;
            if (oe_w[u] === 1'b1) oe_c[u]++;
        end
    end

    function automatic int nbits(input int u); return (u == 3) ? 7 : 8; endfunction
    function automatic int osr(input int u);   return (u == 3) ? 8 : 16; endfunction
    function automatic int pmode(input int u); return (u == 1) ? 1 : (u == 2) ? 2 : 0; endfunction

    // Drives one frame plus one idle bit, then applies the frame rules to the model.
    task automatic send_frame(input int u, input logic [8:0] data, input logic pbit,
                              input logic stopb, input bit pop_res, output logic [8:0] popped);
        int nb, os, pm;
        logic [8:0] d;
        logic xd;
        bit par_ok, was_full;
        nb = nbits(u); os = osr(u); pm = pmode(u);
        d = data & ((9'h1 << nb) - 9'h1);
        popped = '0;
        rx[u] = 1'b0;
        repeat (os) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rx[u] = d[i];
            repeat (os) @(negedge clk);
        end
        if (pm != 0) begin
            rx[u] = pbit;
            repeat (os) @(negedge clk);
        end
        rx[u] = stopb;
        if (pop_res) begin
            // stop bit is resolved 2 sync cycles after its mid-point tick
            repeat (os / 2 + 2) @(negedge clk);
            popped = rdv[u];
            rd_en[u] = 1'b1;
            @(negedge clk);
            rd_en[u] = 1'b0;
            repeat (os - os / 2 - 3) @(negedge clk);
        end else begin
            repeat (os) @(negedge clk);
        end
        rx[u] = 1'b1;
        repeat (os) @(negedge clk);
        xd = ^d;
        par_ok = (pm == 0) || (pm == 1 && (xd ^ pbit) == 1'b0) || (pm == 2 && (xd ^ pbit) == 1'b1);
        was_full = (mq[u].size() == 4);
        if (pop_res && mq[u].size() > 0) void'(mq[u].pop_front());
        if (!stopb)                        exp_fe[u]++;
        else if (!par_ok)                  exp_pe[u]++;
        else if (was_full && !pop_res)     exp_oe[u]++;
        else                               mq[u].push_back(d);
    endtask

    task automatic pop_one(input int u, output logic [8:0] got);
        got = rdv[u];
        rd_en[u] = 1'b1;
        @(negedge clk);
        rd_en[u] = 1'b0;
    endtask

    function automatic logic [8:0] model_pop(input int u);
        if (mq[u].size() == 0) return '0;
        return mq[u].pop_front();
    endfunction

    task automatic test_reset();
        for (int u = 0; u < 4; u++) begin
            rx[u] = 1'b1; rd_en[u] = 1'b0; rst[u] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            total++;
            if (rdv[u] !== 9'h0 || empty_w[u] !== 1'b1 || full_w[u] !== 1'b0 || cnt_w[u] !== 3'd0
                || busy_w[u] !== 1'b0 || fe_w[u] !== 1'b0 || pe_w[u] !== 1'b0 || oe_w[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset u%0d: rd=%h empty=%b full=%b count=%0d busy=%b err=%b%b%b, want 0 1 0 0 0 000",
                         u, rdv[u], empty_w[u], full_w[u], cnt_w[u], busy_w[u], fe_w[u], pe_w[u], oe_w[u]);
            end
            rst[u] = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [8:0] got, exp;
        for (int b = 'h61; b <= 'h64; b++) send_frame(0, 9'(b), 1'b0, 1'b1, 1'b0, got);
        total++;
        if (cnt_w[0] !== 3'd4 || full_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL basic_fill: count=%0d full=%b, want 4 1", cnt_w[0], full_w[0]);
        end
        for (int i = 0; i < 4; i++) begin
            exp = model_pop(0);
            pop_one(0, got);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL basic_pop%0d: got %h want %h", i, got, exp);
            end
        end
        total++;
        if (empty_w[0] !== 1'b1 || rdv[0] !== 9'h0) begin
            bad++;
            $display("FAIL basic_empty: empty=%b rd=%h, want 1 0", empty_w[0], rdv[0]);
        end
    endtask

    task automatic test_glitch();
        int f0, p0, o0;
        f0 = fe_c[0]; p0 = pe_c[0]; o0 = oe_c[0];
        rx[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx[0] = 1'b1;
        total++;
        if (busy_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL glitch_busy_on: busy=%b want 1", busy_w[0]);
        end
        repeat (20) @(negedge clk);
        total++;
        if (busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0 || fe_c[0] != f0 || pe_c[0] != p0 || oe_c[0] != o0) begin
            bad++;
            $display("FAIL glitch_reject: busy=%b count=%0d err_pulses=%0d/%0d/%0d, want 0 0 0/0/0",
                     busy_w[0], cnt_w[0], fe_c[0] - f0, pe_c[0] - p0, oe_c[0] - o0);
        end
    endtask

    task automatic test_parity();
        logic [8:0] got, exp;
        for (int u = 1; u <= 2; u++) begin
            send_frame(u, 9'h07, (u == 1) ? 1'b1 : 1'b0, 1'b1, 1'b0, got);
            total++;
            if (cnt_w[u] !== 3'd1 || pe_c[u] != exp_pe[u]) begin
                bad++;
                $display("FAIL parity_good u%0d: count=%0d perr=%0d, want 1 %0d", u, cnt_w[u], pe_c[u], exp_pe[u]);
            end
            send_frame(u, 9'h07, (u == 1) ? 1'b0 : 1'b1, 1'b1, 1'b0, got);
            total++;
            if (cnt_w[u] !== 3'd1 || pe_c[u] != exp_pe[u] || exp_pe[u] != 1) begin
                bad++;
                $display("FAIL parity_bad u%0d: count=%0d perr=%0d, want 1 1", u, cnt_w[u], pe_c[u]);
            end
            exp = model_pop(u);
            pop_one(u, got);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL parity_data u%0d: got %h want %h", u, got, exp);
            end
        end
    endtask

    task automatic test_framing();
        logic [8:0] got, exp;
        send_frame(0, 9'h55, 1'b0, 1'b0, 1'b0, got);
        total++;
        if (fe_c[0] != exp_fe[0] || cnt_w[0] !== 3'd0) begin
            bad++;
            $display("FAIL frame_err: ferr=%0d count=%0d, want %0d 0", fe_c[0], cnt_w[0], exp_fe[0]);
        end
        send_frame(0, 9'hAA, 1'b0, 1'b1, 1'b0, got);
        exp = model_pop(0);
        pop_one(0, got);
        total++;
        if (got !== exp || exp !== 9'h0AA) begin
            bad++;
            $display("FAIL frame_recover: got %h want 0aa", got);
        end
    endtask

    task automatic test_overrun();
        logic [8:0] got, exp;
        for (int pass = 0; pass < 2; pass++) begin
            for (int b = 1; b <= 5; b++) begin
                exp = (mq[0].size() > 0) ? mq[0][0] : 9'h0;
                send_frame(0, 9'(b), 1'b0, 1'b1, (pass == 1 && b == 5), got);
                if (pass == 1 && b == 5) begin
                    total++;
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL overrun_pop_head: got %h want %h", got, exp);
                    end
                end
            end
            total++;
            if (oe_c[0] != exp_oe[0] || cnt_w[0] !== 3'd4) begin
                bad++;
                $display("FAIL overrun_pass%0d: oerr=%0d count=%0d, want %0d 4", pass, oe_c[0], cnt_w[0], exp_oe[0]);
            end
            for (int i = 0; i < 4; i++) begin
                exp = model_pop(0);
                pop_one(0, got);
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL overrun_drain%0d_%0d: got %h want %h", pass, i, got, exp);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [8:0] got, exp;
        logic [8:0] d;
        send_frame(0, 9'h11, 1'b0, 1'b1, 1'b0, got);
        d = 9'h03C;
        rx[0] = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx[0] = d[i];
            repeat (16) @(negedge clk);
        end
        rx[0] = d[3];
        repeat (8) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        rx[0] = 1'b1;
        mq[0].delete();
        total++;
        if (rdv[0] !== 9'h0 || empty_w[0] !== 1'b1 || full_w[0] !== 1'b0 || cnt_w[0] !== 3'd0
            || busy_w[0] !== 1'b0 || fe_c[0] != exp_fe[0] || pe_c[0] != exp_pe[0] || oe_c[0] != exp_oe[0]) begin
            bad++;
            $display("FAIL midframe_reset: rd=%h empty=%b full=%b count=%0d busy=%b, want 0 1 0 0 0",
                     rdv[0], empty_w[0], full_w[0], cnt_w[0], busy_w[0]);
        end
        repeat (32) @(negedge clk);
        send_frame(0, 9'h3C, 1'b0, 1'b1, 1'b0, got);
        exp = model_pop(0);
        pop_one(0, got);
        total++;
        if (got !== exp || exp !== 9'h03C) begin
            bad++;
            $display("FAIL midframe_recover: got %h want 03c", got);
        end
        send_frame(3, 9'h5A, 1'b0, 1'b1, 1'b0, got);
        total++;
        if (rdv[3] !== 9'h05A || cnt_w[3] !== 3'd1) begin
            bad++;
            $display("FAIL bits7_os8: rd=%h count=%0d, want 05a 1", rdv[3], cnt_w[3]);
        end
        exp = model_pop(3);
        pop_one(3, got);
    endtask

    task automatic test_random();
        logic [8:0] got, exp, d;
        logic pbit;
        bit pr;
        for (int u = 1; u <= 3; u++) begin
            for (int n = 0; n < 12; n++) begin
                d = 9'($urandom_range(0, 511)) & ((9'h1 << nbits(u)) - 9'h1);
                pbit = (pmode(u) == 2) ? ~(^d) : ^d;
                if ($urandom_range(0, 3) == 0) pbit = ~pbit;
                pr = ($urandom_range(0, 3) == 0);
                exp = (mq[u].size() > 0) ? mq[u][0] : 9'h0;
                send_frame(u, d, pbit, ($urandom_range(0, 5) != 0), pr, got);
                total++;
                if (cnt_w[u] !== 3'(mq[u].size()) || fe_c[u] != exp_fe[u] || pe_c[u] != exp_pe[u]
                    || oe_c[u] != exp_oe[u] || (pr && got !== exp)) begin
                    bad++;
                    $display("FAIL random u%0d n%0d: count=%0d/%0d fe=%0d/%0d pe=%0d/%0d oe=%0d/%0d head=%h/%h",
                             u, n, cnt_w[u], mq[u].size(), fe_c[u], exp_fe[u], pe_c[u], exp_pe[u],
                             oe_c[u], exp_oe[u], got, exp);
                end
                if ($urandom_range(0, 2) == 0) begin
                    exp = model_pop(u);
                    pop_one(u, got);
                    total++;
                    if (got !== exp) begin
                        bad++;
                        $display("FAIL random_pop u%0d n%0d: got %h want %h", u, n, got, exp);
                    end
                end
            end
            while (mq[u].size() > 0) begin
                exp = model_pop(u);
                pop_one(u, got);
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL random_drain u%0d: got %h want %h", u, got, exp);
                end
            end
            total++;
            if (empty_w[u] !== 1'b1) begin
                bad++;
                $display("FAIL random_empty u%0d: empty=%b want 1", u, empty_w[u]);
            end
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        b_tick = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
